// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the vectoring CORDIC.
//   ANGLE_90   : +90 degrees as a 32-bit binary angle (2^32 = full turn).
//   INV_GAIN   : 1/K in Q1.31, used when CORDIC_GAIN_COMP_EN is defined.
//   state_t    : FSM encoding of cordic_vectoring_iter.
//   atan32()   : atan(2^-i) as a 32-bit binary angle, i = 0..31.
package cordic_pkg;

  localparam logic [31:0] ANGLE_90 = 32'h4000_0000;
  localparam logic [31:0] INV_GAIN = 32'h4DBA_76D4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROT   = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Arctangent table; entries past index 12 are essentially 2^32/(2*pi*2^i).
  function automatic logic [31:0] atan32(input logic [4:0] idx);
    case (idx)
      5'd0:    atan32 = 32'h2000_0000;
      5'd1:    atan32 = 32'h12E4_051E;
      5'd2:    atan32 = 32'h09FB_385B;
      5'd3:    atan32 = 32'h0511_11D4;
      5'd4:    atan32 = 32'h028B_0D43;
      5'd5:    atan32 = 32'h0145_D7E1;
      5'd6:    atan32 = 32'h00A2_F61E;
      5'd7:    atan32 = 32'h0051_7C55;
      5'd8:    atan32 = 32'h0028_BE53;
      5'd9:    atan32 = 32'h0014_5F2F;
      5'd10:   atan32 = 32'h000A_2F98;
      5'd11:   atan32 = 32'h0005_17CC;
      5'd12:   atan32 = 32'h0002_8BE6;
      5'd13:   atan32 = 32'h0001_45F3;
      5'd14:   atan32 = 32'h0000_A2FA;
      5'd15:   atan32 = 32'h0000_517D;
      5'd16:   atan32 = 32'h0000_28BE;
      5'd17:   atan32 = 32'h0000_145F;
      5'd18:   atan32 = 32'h0000_0A30;
      5'd19:   atan32 = 32'h0000_0518;
      5'd20:   atan32 = 32'h0000_028C;
      5'd21:   atan32 = 32'h0000_0146;
      5'd22:   atan32 = 32'h0000_00A3;
      5'd23:   atan32 = 32'h0000_0051;
      5'd24:   atan32 = 32'h0000_0029;
      5'd25:   atan32 = 32'h0000_0014;
      5'd26:   atan32 = 32'h0000_000A;
      5'd27:   atan32 = 32'h0000_0005;
      5'd28:   atan32 = 32'h0000_0003;
      5'd29:   atan32 = 32'h0000_0001;
      5'd30:   atan32 = 32'h0000_0001;
      5'd31:   atan32 = 32'h0000_0000;
      default: atan32 = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// cordic_vec_step: one combinational vectoring micro-rotation.
//   x, y   : current vector (signed, XW bits)
//   z      : accumulated angle (binary angle, ZW bits, wraps)
//   shift  : iteration index i (arithmetic shift amount)
//   atan   : atan(2^-i) in the same angle format as z
//   x_next, y_next, z_next : rotated vector and updated angle
// The rotation direction is chosen to push y toward zero.
module cordic_vec_step #(
  parameter int XW = 34,
  parameter int ZW = 32,
  parameter int SW = 5
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic        [ZW-1:0] z,
  input  logic        [SW-1:0] shift,
  input  logic        [ZW-1:0] atan,
  output logic signed [XW-1:0] x_next,
  output logic signed [XW-1:0] y_next,
  output logic        [ZW-1:0] z_next
);

  logic signed [XW-1:0] x_sh_s;
  logic signed [XW-1:0] y_sh_s;

  // Simultaneous x/y update from the old values; sign of y picks direction.
  always_comb begin
    x_sh_s = x >>> shift;
    y_sh_s = y >>> shift;
    if (!y[XW-1]) begin
      x_next = x + y_sh_s;
      y_next = y - x_sh_s;
      z_next = z + atan;
    end else begin
      x_next = x - y_sh_s;
      y_next = y + x_sh_s;
      z_next = z - atan;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// cordic_vectoring_iter: iterative vectoring-mode CORDIC returning the
// magnitude and phase (atan2) of (x_in, y_in), one micro-rotation per clock.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready high only in IDLE)
//   x_in, y_in          : signed input vector
//   out_valid/out_ready : output handshake
//   mag_out             : unsigned magnitude, WIDTH+1 bits
//   ang_out             : binary angle, 2^WIDTH = full turn
// Optional macro CORDIC_GAIN_COMP_EN adds a SCALE state that multiplies the
// magnitude by 1/K so mag_out approximates the true length.
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   mag_out,
  output logic [WIDTH-1:0] ang_out
);

  localparam int XW = WIDTH + 2;
  // 32-bit angle constants rescaled to WIDTH bits.
  localparam logic [WIDTH-1:0] ANG90_W = WIDTH'({ANGLE_90, 32'h0000_0000} >> (64 - WIDTH));

`ifdef CORDIC_GAIN_COMP_EN
  localparam state_t ST_AFTER_ROT = ST_SCALE;
`else
  localparam state_t ST_AFTER_ROT = ST_DONE;
`endif

  state_t               state_r, state_next_s;
  logic signed [XW-1:0] x_r, y_r, x_next_s, y_next_s;
  logic signed [XW-1:0] x_ext_s, y_ext_s, x_pre_s, y_pre_s;
  logic [WIDTH-1:0]     z_r, z_next_s, z_pre_s, atan_s;
  logic [4:0]           i_r;
  logic                 zero_flag_r, last_s;
  logic                 in_ready_r, in_ready_d_s, out_valid_r, out_valid_d_s;
  logic [WIDTH:0]       mag_out_r;
  logic [WIDTH-1:0]     ang_out_r;

  assign last_s = (i_r == 5'(ITER - 1));
  assign atan_s = WIDTH'({atan32(i_r), 32'h0000_0000} >> (64 - WIDTH));

  cordic_vec_step #(.XW(XW), .ZW(WIDTH), .SW(5)) u_step (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .shift  (i_r),
    .atan   (atan_s),
    .x_next (x_next_s),
    .y_next (y_next_s),
    .z_next (z_next_s)
  );

`ifdef CORDIC_GAIN_COMP_EN
  logic [WIDTH+32:0] prod_s;
  logic [WIDTH:0]    mag_scaled_s;
  // x is non-negative after ROT, so an unsigned Q1.31 multiply is exact.
  always_comb begin
    prod_s       = (WIDTH+33)'(x_r[WIDTH:0]) * (WIDTH+33)'(INV_GAIN);
    mag_scaled_s = (WIDTH+1)'(prod_s >> 31);
  end
`else
`endif

  // Quadrant pre-rotation brings the vector into the right half-plane.
  always_comb begin
    x_ext_s = {{2{x_in[WIDTH-1]}}, x_in};
    y_ext_s = {{2{y_in[WIDTH-1]}}, y_in};
    if (!x_in[WIDTH-1]) begin
      x_pre_s = x_ext_s;
      y_pre_s = y_ext_s;
      z_pre_s = {WIDTH{1'b0}};
    end else if (!y_in[WIDTH-1]) begin
      x_pre_s = y_ext_s;
      y_pre_s = -x_ext_s;
      z_pre_s = ANG90_W;
    end else begin
      x_pre_s = -y_ext_s;
      y_pre_s = x_ext_s;
      z_pre_s = -ANG90_W;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (in_valid) state_next_s = ST_ROT;  else state_next_s = ST_IDLE;
      ST_ROT:   if (last_s) state_next_s = ST_AFTER_ROT; else state_next_s = ST_ROT;
      ST_SCALE: state_next_s = ST_DONE;
      ST_DONE:  if (out_ready) state_next_s = ST_IDLE; else state_next_s = ST_DONE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, then registered.
  always_comb begin
    in_ready_d_s  = (state_next_s == ST_IDLE);
    out_valid_d_s = (state_next_s == ST_DONE);
  end

  // Handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_d_s;
      out_valid_r <= out_valid_d_s;
    end
  end

  // Datapath: load, iterate, and capture results on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r         <= {XW{1'b0}};
      y_r         <= {XW{1'b0}};
      z_r         <= {WIDTH{1'b0}};
      i_r         <= 5'd0;
      zero_flag_r <= 1'b0;
      mag_out_r   <= {(WIDTH+1){1'b0}};
      ang_out_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x_r         <= x_pre_s;
            y_r         <= y_pre_s;
            z_r         <= z_pre_s;
            i_r         <= 5'd0;
            zero_flag_r <= (x_in == {WIDTH{1'b0}}) && (y_in == {WIDTH{1'b0}});
          end
        end
        ST_ROT: begin
          x_r <= x_next_s;
          y_r <= y_next_s;
          z_r <= z_next_s;
          i_r <= i_r + 5'd1;
          if (last_s) begin
`ifdef CORDIC_GAIN_COMP_EN
            // Results are captured after the SCALE cycle.
`else
            mag_out_r <= zero_flag_r ? {(WIDTH+1){1'b0}} : x_next_s[WIDTH:0];
            ang_out_r <= zero_flag_r ? {WIDTH{1'b0}} : z_next_s;
`endif
          end
        end
        ST_SCALE: begin
`ifdef CORDIC_GAIN_COMP_EN
          mag_out_r <= zero_flag_r ? {(WIDTH+1){1'b0}} : mag_scaled_s;
          ang_out_r <= zero_flag_r ? {WIDTH{1'b0}} : z_r;
`else
`endif
        end
        ST_DONE: begin
          // Results hold while the consumer stalls.
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign mag_out   = mag_out_r;
  assign ang_out   = ang_out_r;

endmodule
